// File: rtl/echo_distance.sv
// Converts an ultrasonic echo pulse width (clk cycles) to centimetres with a
// serial restoring divider, flags out-of-range/missing echoes and drives a hysteretic alarm.
module echo_distance #(
   parameter int CNT_W        = 24,
   parameter int DIST_W       = 9,
   parameter int CYC_PER_CM   = 2900,
   parameter int MAX_CM       = 400,
   parameter int ALARM_ON_CM  = 20,
   parameter int ALARM_OFF_CM = 25,
   parameter int TIMEOUT_CYC  = 15000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              echo_pin,
   input  logic [CNT_W-1:0]  echo_counter,
   output logic [DIST_W-1:0] distance_cm,
   output logic              dist_valid,
   output logic              out_of_range,
   output logic              no_echo,
   output logic              busy,
   output logic              alarm
);

   localparam int RW     = CNT_W + 1;
   localparam int TW     = CNT_W + 2;
   localparam int ITER_W = $clog2(CNT_W + 1);
   localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] DIVISOR = TW'(CYC_PER_CM);

   typedef enum logic [1:0] {IDLE, CAPTURE, DIVIDE, DONE} state_t;

   state_t              state, state_nx;
   logic                echo_d;
   logic                fall;
   logic [CNT_W-1:0]    quot;
   logic [RW-1:0]       rem;
   logic [TW-1:0]       trial;
   logic                take;
   logic [ITER_W-1:0]   iter;
   logic [TMO_W-1:0]    tmo;

   assign fall = echo_d & ~echo_pin;

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   assign trial = {rem, quot[CNT_W-1]};
   assign take  = (trial >= DIVISOR);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_nx = state;
      busy     = 1'b1;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (fall) state_nx = CAPTURE;
         end
         CAPTURE: state_nx = DIVIDE;
         DIVIDE:  if (iter == ITER_W'(CNT_W - 1)) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         echo_d       <= 1'b0;
         quot         <= '0;
         rem          <= '0;
         iter         <= '0;
         tmo          <= '0;
         distance_cm  <= '0;
         dist_valid   <= 1'b0;
         out_of_range <= 1'b0;
         no_echo      <= 1'b0;
         alarm        <= 1'b0;
      end else begin
         echo_d     <= echo_pin;
         dist_valid <= (state == DONE);

         // Any fall, even one ignored while busy, proves the sensor is alive.
         if (fall)                             tmo <= '0;
         else if (tmo != TMO_W'(TIMEOUT_CYC)) tmo <= tmo + 1'b1;
         no_echo <= (tmo == TMO_W'(TIMEOUT_CYC));

         unique case (state)
            CAPTURE: begin
               quot <= echo_counter;
               rem  <= '0;
               iter <= '0;
            end
            DIVIDE: begin
               quot <= {quot[CNT_W-2:0], take};
               rem  <= take ? RW'(trial - DIVISOR) : RW'(trial);
               iter <= iter + 1'b1;
            end
            DONE: begin
               if (quot == '0) begin
                  distance_cm  <= '0;
                  out_of_range <= 1'b1;
               end else if (quot > CNT_W'(MAX_CM)) begin
                  distance_cm  <= DIST_W'(MAX_CM);
                  out_of_range <= 1'b1;
                  alarm        <= 1'b0;
               end else begin
                  distance_cm  <= quot[DIST_W-1:0];
                  out_of_range <= 1'b0;
                  if (quot <= CNT_W'(ALARM_ON_CM))       alarm <= 1'b1;
                  else if (quot >= CNT_W'(ALARM_OFF_CM)) alarm <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_echo_distance.sv
// Randomised self-checking bench for echo_distance against a plain-arithmetic
// reference model (floor division, saturation and alarm hysteresis).
module tb_echo_distance;

   localparam int CNT_W   = 24;
   localparam int DIST_W  = 9;
   localparam int TMO     = 3000;
   localparam int LATENCY = CNT_W + 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              echo_pin;
   logic [CNT_W-1:0]  echo_counter;
   logic [DIST_W-1:0] distance_cm;
   logic              dist_valid;
   logic              out_of_range;
   logic              no_echo;
   logic              busy;
   logic              alarm;

   int tests = 0;
   int fails = 0;

   int exp_dist  = 0;
   bit exp_oor   = 1'b0;
   bit exp_alarm = 1'b0;

   echo_distance #(
      .CNT_W(CNT_W), .DIST_W(DIST_W), .CYC_PER_CM(2900), .MAX_CM(400),
      .ALARM_ON_CM(20), .ALARM_OFF_CM(25), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .rst(rst), .echo_pin(echo_pin), .echo_counter(echo_counter),
      .distance_cm(distance_cm), .dist_valid(dist_valid), .out_of_range(out_of_range),
      .no_echo(no_echo), .busy(busy), .alarm(alarm)
   );

   always #10 clk = ~clk;

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Reference: centimetres are floor(width / 2900), saturated, with hysteretic alarm.
   function automatic void model(input int unsigned width);
      int unsigned cm;
      cm = width / 2900;
      if (cm == 0) begin
         exp_dist = 0;
         exp_oor  = 1'b1;
      end else if (cm > 400) begin
         exp_dist  = 400;
         exp_oor   = 1'b1;
         exp_alarm = 1'b0;
      end else begin
         exp_dist = int'(cm);
         exp_oor  = 1'b0;
         if (cm <= 20)      exp_alarm = 1'b1;
         else if (cm >= 25) exp_alarm = 1'b0;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Echo pulse, then wait for dist_valid; lat counts edges after the detection edge.
   task automatic run_meas(input int unsigned width, output int lat, output bit got);
      echo_pin     = 1'b1;
      echo_counter = CNT_W'($urandom);
      tick();
      tick();
      echo_counter = CNT_W'(width);
      echo_pin     = 1'b0;
      got = 1'b0;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (dist_valid) begin
            got = 1'b1;
            lat = n - 1;
            break;
         end
      end
      model(width);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      echo_pin = 1'b0;
      echo_counter = '0;
      repeat (3) tick();
      tests++;
      if ({distance_cm, dist_valid, out_of_range, no_echo, busy, alarm} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: dist=%0d valid=%0b oor=%0b no_echo=%0b busy=%0b alarm=%0b, expected all 0",
                  distance_cm, dist_valid, out_of_range, no_echo, busy, alarm);
      end
      rst = 1'b0;
      repeat (3) tick();
      tests++;
      if (busy !== 1'b0 || dist_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_no_false_fall: busy=%0b valid=%0b, expected 0 0", busy, dist_valid);
      end
   endtask

   task automatic test_basic();
      int lat;
      bit got;
      run_meas(58000, lat, got);
      tests++;
      if (!got || lat != LATENCY) begin
         fails++;
         $display("FAIL basic_latency: got=%0b latency=%0d, expected 1 %0d", got, lat, LATENCY);
      end
      tests++;
      if (distance_cm !== 9'd20 || out_of_range !== 1'b0 || alarm !== 1'b1) begin
         fails++;
         $display("FAIL basic_result: dist=%0d oor=%0b alarm=%0b, expected 20 0 1",
                  distance_cm, out_of_range, alarm);
      end
      tick();
      tests++;
      if (dist_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL basic_pulse_width: valid=%0b busy=%0b, expected 0 0", dist_valid, busy);
      end
   endtask

   task automatic test_hysteresis();
      int unsigned widths [4] = '{63800, 72500, 63800, 57999};
      int lat;
      bit got;
      foreach (widths[i]) begin
         run_meas(widths[i], lat, got);
         tests++;
         if (!got || lat != LATENCY) begin
            fails++;
            $display("FAIL hyst_latency[%0d]: got=%0b latency=%0d, expected 1 %0d", i, got, lat, LATENCY);
         end
         tests++;
         if (distance_cm !== exp_dist[DIST_W-1:0] || out_of_range !== exp_oor || alarm !== exp_alarm) begin
            fails++;
            $display("FAIL hyst_result[%0d]: dist=%0d oor=%0b alarm=%0b, expected %0d %0b %0b",
                     i, distance_cm, out_of_range, alarm, exp_dist, exp_oor, exp_alarm);
         end
      end
   endtask

   task automatic test_boundaries();
      int unsigned widths [5] = '{1160000, 1162900, 2899, 57999, 0};
      int lat;
      bit got;
      foreach (widths[i]) begin
         run_meas(widths[i], lat, got);
         tests++;
         if (!got || lat != LATENCY || distance_cm !== exp_dist[DIST_W-1:0] ||
             out_of_range !== exp_oor || alarm !== exp_alarm) begin
            fails++;
            $display("FAIL boundary[%0d] width=%0d: got=%0b lat=%0d dist=%0d oor=%0b alarm=%0b, expected lat=%0d %0d %0b %0b",
                     i, widths[i], got, lat, distance_cm, out_of_range, alarm,
                     LATENCY, exp_dist, exp_oor, exp_alarm);
         end
      end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      int first  = -1;
      echo_pin = 1'b1;
      echo_counter = '0;
      tick();
      tick();
      echo_counter = CNT_W'(87000);
      echo_pin = 1'b0;
      model(87000);
      for (int n = 1; n <= 60; n++) begin
         tick();
         if (n == 5) begin
            echo_pin = 1'b1;
            echo_counter = CNT_W'(29000);
         end
         if (n == 10) echo_pin = 1'b0;
         if (dist_valid) begin
            pulses++;
            if (first < 0) first = n - 1;
            if (pulses == 1) begin
               tests++;
               if (distance_cm !== exp_dist[DIST_W-1:0] || out_of_range !== exp_oor || alarm !== exp_alarm) begin
                  fails++;
                  $display("FAIL b2b_result: dist=%0d oor=%0b alarm=%0b, expected %0d %0b %0b",
                           distance_cm, out_of_range, alarm, exp_dist, exp_oor, exp_alarm);
               end
            end
         end
      end
      tests++;
      if (pulses != 1 || first != LATENCY) begin
         fails++;
         $display("FAIL b2b_pulses: pulses=%0d latency=%0d, expected 1 %0d", pulses, first, LATENCY);
      end
   endtask

   task automatic test_random();
      int unsigned width;
      int lat;
      bit got;
      for (int i = 0; i < 16; i++) begin
         if (i % 3 == 0) width = $urandom_range(18 * 2900, 27 * 2900);
         else            width = $urandom_range(0, 1300000);
         run_meas(width, lat, got);
         tests++;
         if (!got || lat != LATENCY || distance_cm !== exp_dist[DIST_W-1:0] ||
             out_of_range !== exp_oor || alarm !== exp_alarm) begin
            fails++;
            $display("FAIL random[%0d] width=%0d: got=%0b lat=%0d dist=%0d oor=%0b alarm=%0b, expected lat=%0d %0d %0b %0b",
                     i, width, got, lat, distance_cm, out_of_range, alarm,
                     LATENCY, exp_dist, exp_oor, exp_alarm);
         end
         repeat ($urandom_range(0, 5)) tick();
      end
   endtask

   task automatic test_timeout();
      int lat;
      bit got;
      echo_pin = 1'b0;
      tick();
      tests++;
      if (no_echo !== 1'b0) begin
         fails++;
         $display("FAIL timeout_early: no_echo=%0b, expected 0", no_echo);
      end
      repeat (TMO + 5) tick();
      tests++;
      if (no_echo !== 1'b1 || distance_cm !== exp_dist[DIST_W-1:0]) begin
         fails++;
         $display("FAIL timeout_assert: no_echo=%0b dist=%0d, expected 1 %0d", no_echo, distance_cm, exp_dist);
      end
      run_meas(290000, lat, got);
      tests++;
      if (!got || lat != LATENCY || no_echo !== 1'b0 || distance_cm !== 9'd100 || out_of_range !== 1'b0) begin
         fails++;
         $display("FAIL timeout_recover: got=%0b lat=%0d no_echo=%0b dist=%0d oor=%0b, expected 1 %0d 0 100 0",
                  got, lat, no_echo, distance_cm, out_of_range, LATENCY);
      end
   endtask

   task automatic test_reset_mid_divide();
      int pulses = 0;
      int lat;
      bit got;
      echo_pin = 1'b1;
      tick();
      tick();
      echo_counter = CNT_W'(290000);
      echo_pin = 1'b0;
      repeat (12) tick();
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL abort_busy: busy=%0b, expected 1", busy);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_dist = 0;
      exp_oor = 1'b0;
      exp_alarm = 1'b0;
      tests++;
      if ({distance_cm, dist_valid, out_of_range, no_echo, busy, alarm} !== '0) begin
         fails++;
         $display("FAIL abort_outputs: dist=%0d valid=%0b oor=%0b no_echo=%0b busy=%0b alarm=%0b, expected all 0",
                  distance_cm, dist_valid, out_of_range, no_echo, busy, alarm);
      end
      for (int n = 0; n < 40; n++) begin
         tick();
         if (dist_valid) pulses++;
      end
      tests++;
      if (pulses != 0) begin
         fails++;
         $display("FAIL abort_no_valid: pulses=%0d, expected 0", pulses);
      end
      run_meas(58000, lat, got);
      tests++;
      if (!got || lat != LATENCY || distance_cm !== 9'd20 || out_of_range !== 1'b0 || alarm !== 1'b1) begin
         fails++;
         $display("FAIL abort_recover: got=%0b lat=%0d dist=%0d oor=%0b alarm=%0b, expected 1 %0d 20 0 1",
                  got, lat, distance_cm, out_of_range, alarm, LATENCY);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hysteresis();
      test_boundaries();
      test_back_to_back();
      test_random();
      test_timeout();
      test_reset_mid_divide();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
